// File: rtl/reqrsp_to_mem_amo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reqrsp_to_mem_amo: reqrsp port onto a req/gnt SRAM, atomics done as RMW.  |
// | Optional LR/SC reservation: define REQRSP_AMO_LRSC_EN.     Revision: 1.0  |
// +---------------------------------------------------------------------------+
module reqrsp_to_mem_amo #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64,
    parameter int StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic [StrbWidth-1:0] req_strb_i,
    input  logic [2:0]           req_size_i,
    input  logic [3:0]           req_amo_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 rsp_error_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [StrbWidth-1:0] mem_be_o,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i
);
    localparam logic [3:0] AMO_NONE = 4'h0, AMO_SWAP = 4'h1, AMO_ADD  = 4'h2, AMO_AND  = 4'h3,
                           AMO_OR   = 4'h4, AMO_XOR  = 4'h5, AMO_MAX  = 4'h6, AMO_MAXU = 4'h7,
                           AMO_MIN  = 4'h8, AMO_MINU = 4'h9, AMO_LR   = 4'hA, AMO_SC   = 4'hB;
    localparam int OFFS = $clog2(StrbWidth);
    localparam logic [2:0] IDLE = 3'd0, MEM_RD = 3'd1, WAIT_RD = 3'd2,
                           MEM_WR = 3'd3, WAIT_WR = 3'd4, RESP = 3'd5;

    logic [2:0]           state, state_next;
    logic                 accept, is_amo_op, is_illegal, size_ok, is_lr, is_sc;
    logic                 sc_pass, sc_fail, go_err, go_store, lane_hi_in;
    logic [AddrWidth-1:0] addr_aligned;
    logic [7:0]           amo_be;
    logic                 unused_addr_bits;

    logic                 amo_q, wide_q, lane_hi_q;
    logic [3:0]           op_q;
    logic [DataWidth-1:0] operand_q, wdata_q, rsp_data_q;
    logic [AddrWidth-1:0] addr_q;
    logic [StrbWidth-1:0] be_q;
    logic                 rsp_error_q;

    logic [63:0] old_ext, opnd_ext, alu_a, alu_b, alu_res, new_ext;
    logic [31:0] old32, op32;

    // Narrow operands arrive zero-extended, so the unsigned compare is exact on W bits.
    function automatic logic [63:0] amo_alu(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input logic wide);
        logic sa, sb, lt_u, lt_s;
        logic [63:0] r;
        sa   = wide ? a[63] : a[31];
        sb   = wide ? b[63] : b[31];
        lt_u = a < b;
        lt_s = (sa != sb) ? sa : lt_u;
        case (op)
            AMO_SWAP: r = b;
            AMO_ADD:  r = a + b;
            AMO_AND:  r = a & b;
            AMO_OR:   r = a | b;
            AMO_XOR:  r = a ^ b;
            AMO_MAX:  r = lt_s ? b : a;
            AMO_MAXU: r = lt_u ? b : a;
            AMO_MIN:  r = lt_s ? a : b;
            AMO_MINU: r = lt_u ? a : b;
            default:  r = a;
        endcase
        return r;
    endfunction

    assign accept           = (state == IDLE) && req_valid_i;
    assign addr_aligned     = {req_addr_i[AddrWidth-1:OFFS], {OFFS{1'b0}}};
    assign unused_addr_bits = ^req_addr_i[OFFS-1:0];
    assign is_amo_op        = (req_amo_i >= AMO_SWAP) && (req_amo_i <= AMO_MINU);
    assign is_illegal       = (req_amo_i >= 4'hC);
    assign is_lr            = (req_amo_i == AMO_LR);
    assign is_sc            = (req_amo_i == AMO_SC);
    assign size_ok          = (req_size_i == 3'd2) || ((req_size_i == 3'd3) && (DataWidth == 64));
    assign lane_hi_in       = (DataWidth == 64) && req_addr_i[2];
    assign amo_be           = (req_size_i == 3'd3) ? 8'hFF : (lane_hi_in ? 8'hF0 : 8'h0F);

`ifdef REQRSP_AMO_LRSC_EN
    logic                 resv_valid;
    logic [AddrWidth-1:0] resv_addr;

    assign sc_pass  = is_sc && resv_valid && (resv_addr == addr_aligned);
    assign sc_fail  = is_sc && !sc_pass;
    assign go_err   = is_illegal || (is_amo_op && !size_ok);
    assign go_store = ((req_amo_i == AMO_NONE) && req_write_i) || sc_pass;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else if (accept && is_lr) begin
            resv_valid <= 1'b1;
            resv_addr  <= addr_aligned;
        end else if (accept && is_sc) begin
            resv_valid <= 1'b0;
        end else if ((state == MEM_WR) && mem_gnt_i && (addr_q == resv_addr)) begin
            resv_valid <= 1'b0;
        end
    end
`else
    assign sc_pass  = 1'b0;
    assign sc_fail  = 1'b0;
    assign go_err   = is_illegal || (is_amo_op && !size_ok) || is_sc;
    assign go_store = (req_amo_i == AMO_NONE) && req_write_i && !sc_pass;
`endif

    // Read-modify-write datapath: only the selected lane changes, the rest is read back.
    always_comb begin
        old_ext  = 64'(mem_rdata_i);
        opnd_ext = 64'(operand_q);
        old32    = lane_hi_q ? old_ext[63:32] : old_ext[31:0];
        op32     = lane_hi_q ? opnd_ext[63:32] : opnd_ext[31:0];
        alu_a    = wide_q ? old_ext : {32'b0, old32};
        alu_b    = wide_q ? opnd_ext : {32'b0, op32};
        alu_res  = amo_alu(op_q, alu_a, alu_b, wide_q);
        if (wide_q)         new_ext = alu_res;
        else if (lane_hi_q) new_ext = {alu_res[31:0], old_ext[31:0]};
        else                new_ext = {old_ext[63:32], alu_res[31:0]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            amo_q       <= 1'b0;
            wide_q      <= 1'b0;
            lane_hi_q   <= 1'b0;
            op_q        <= AMO_NONE;
            operand_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            if (accept) begin
                amo_q       <= is_amo_op;
                wide_q      <= (req_size_i == 3'd3);
                lane_hi_q   <= lane_hi_in;
                op_q        <= req_amo_i;
                operand_q   <= req_data_i;
                addr_q      <= addr_aligned;
                wdata_q     <= req_data_i;
                rsp_data_q  <= {{(DataWidth-1){1'b0}}, sc_fail};
                rsp_error_q <= go_err;
                if (is_amo_op)     be_q <= amo_be[StrbWidth-1:0];
                else if (go_store) be_q <= req_strb_i;
                else               be_q <= '1;
            end
            if ((state == WAIT_RD) && mem_rvalid_i) begin
                rsp_data_q <= mem_rdata_i;
                wdata_q    <= new_ext[DataWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid_i) begin
                if (go_err || sc_fail) state_next = RESP;
                else if (go_store)     state_next = MEM_WR;
                else                   state_next = MEM_RD;
            end
            MEM_RD:  if (mem_gnt_i)    state_next = WAIT_RD;
            WAIT_RD: if (mem_rvalid_i) state_next = amo_q ? MEM_WR : RESP;
            MEM_WR:  if (mem_gnt_i)    state_next = WAIT_WR;
            WAIT_WR: if (mem_rvalid_i) state_next = RESP;
            RESP:    if (rsp_ready_i)  state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state == IDLE);
        mem_req_o   = (state == MEM_RD) || (state == MEM_WR);
        mem_we_o    = (state == MEM_WR);
        rsp_valid_o = (state == RESP);
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_error_o = rsp_error_q;

endmodule
`default_nettype wire

// File: tb/tb_reqrsp_to_mem_amo.sv
`default_nettype none
// Directed bench for reqrsp_to_mem_amo with a req/gnt memory model (rvalid one cycle after gnt).
module tb_reqrsp_to_mem_amo;
    localparam logic [3:0] OP_NONE = 4'h0, OP_SWAP = 4'h1, OP_ADD = 4'h2, OP_XOR = 4'h5,
                           OP_MAX = 4'h6, OP_MAXU = 4'h7, OP_MINU = 4'h9,
                           OP_LR = 4'hA, OP_SC = 4'hB;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic [7:0]  req_strb;
    logic [2:0]  req_size;
    logic [3:0]  req_amo;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [63:0] rsp_data;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_be;

    logic        gnt_en;
    logic        poke_en = 1'b0;
    int          poke_idx;
    logic [63:0] poke_val;
    logic [63:0] mem [0:15];
    int          rd_cnt = 0, wr_cnt = 0;
    logic [7:0]  last_rbe, last_wbe;
    logic [31:0] last_raddr;
    logic [63:0] last_wdata;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign mem_gnt = gnt_en;

    reqrsp_to_mem_amo dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_data_i(req_data), .req_strb_i(req_strb),
        .req_size_i(req_size), .req_amo_i(req_amo),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_error_o(rsp_error),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (poke_en) mem[poke_idx] <= poke_val;
        if (mem_req && mem_gnt) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= mem[mem_addr[6:3]];
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be[b]) mem[mem_addr[6:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                wr_cnt     <= wr_cnt + 1;
                last_wbe   <= mem_be;
                last_wdata <= mem_wdata;
            end else begin
                rd_cnt     <= rd_cnt + 1;
                last_rbe   <= mem_be;
                last_raddr <= mem_addr;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [63:0] val);
        poke_idx = idx;
        poke_val = val;
        poke_en  = 1'b1;
        @(posedge clk); #1;
        poke_en  = 1'b0;
    endtask

    // lat = cycle index (accept cycle = 0) in which rsp_valid is first seen.
    task automatic run_req(input logic [3:0] amo, input logic wr, input logic [31:0] addr,
                           input logic [63:0] data, input logic [7:0] strb, input logic [2:0] size,
                           output int lat, output logic [63:0] rdata, output logic err);
        int n;
        req_amo = amo; req_write = wr; req_addr = addr;
        req_data = data; req_strb = strb; req_size = size;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        rdata = rsp_data;
        err   = rsp_error;
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat, rc, wc;
        logic [63:0] rd;
        logic        er;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        req_strb = '0; req_size = 3'd3; req_amo = OP_NONE; rsp_ready = 1'b1; gnt_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_mem_req",   64'(mem_req),   64'd0);
        check_eq("rst_mem_we",    64'(mem_we),    64'd0);
        check_eq("rst_mem_addr",  64'(mem_addr),  64'd0);
        check_eq("rst_mem_wdata", mem_wdata,      64'd0);
        check_eq("rst_mem_be",    64'(mem_be),    64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_data",  rsp_data,       64'd0);
        check_eq("rst_rsp_error", 64'(rsp_error), 64'd0);
        rst = 1'b0;

        poke(2, 64'hDEADBEEF_01234567);
        poke(0, 64'hFFFFFFFF_12345678);
        poke(4, 64'h11111111_80000000);
        poke(5, 64'h11111111_80000000);
        poke(6, 64'h5);
        poke(7, 64'hF0F0F0F0_AAAAAAAA);
        poke(9, 64'h1234);
        poke(10, 64'h0);

        // Plain load
        rc = rd_cnt;
        run_req(OP_NONE, 1'b0, 32'h10, 64'h0, 8'h00, 3'd3, lat, rd, er);
        check_eq("load_lat",   64'(lat), 64'd3);
        check_eq("load_data",  rd, 64'hDEADBEEF_01234567);
        check_eq("load_err",   64'(er), 64'd0);
        check_eq("load_be",    64'(last_rbe), 64'hFF);
        check_eq("load_addr",  64'(last_raddr), 64'h10);
        check_eq("load_reads", 64'(rd_cnt - rc), 64'd1);

        // Plain store with partial strobes
        run_req(OP_NONE, 1'b1, 32'h50, 64'h11223344_55667788, 8'h0F, 3'd3, lat, rd, er);
        check_eq("st_lat",  64'(lat), 64'd3);
        check_eq("st_data", rd, 64'd0);
        check_eq("st_be",   64'(last_wbe), 64'h0F);
        check_eq("st_mem",  mem[10], 64'h00000000_55667788);

        // AMOAdd upper lane wraps to zero
        run_req(OP_ADD, 1'b0, 32'h4, 64'h00000001_00000000, 8'h00, 3'd2, lat, rd, er);
        check_eq("add_lat",  64'(lat), 64'd5);
        check_eq("add_rsp",  rd, 64'hFFFFFFFF_12345678);
        check_eq("add_be",   64'(last_wbe), 64'hF0);
        check_eq("add_wr",   64'(last_wdata[63:32]), 64'h0);
        check_eq("add_mem",  mem[0], 64'h00000000_12345678);

        // Signed vs unsigned max
        run_req(OP_MAX, 1'b0, 32'h20, 64'h1, 8'h00, 3'd2, lat, rd, er);
        check_eq("max_wr",  64'(last_wdata[31:0]), 64'h00000001);
        check_eq("max_be",  64'(last_wbe), 64'h0F);
        check_eq("max_rsp", rd, 64'h11111111_80000000);
        run_req(OP_MAXU, 1'b0, 32'h28, 64'h1, 8'h00, 3'd2, lat, rd, er);
        check_eq("maxu_wr",  64'(last_wdata[31:0]), 64'h80000000);
        check_eq("maxu_mem", mem[5], 64'h11111111_80000000);

        // 64-bit MINU, XOR in upper lane, 64-bit SWAP
        run_req(OP_MINU, 1'b0, 32'h30, 64'h3, 8'h00, 3'd3, lat, rd, er);
        check_eq("minu_mem", mem[6], 64'h3);
        check_eq("minu_be",  64'(last_wbe), 64'hFF);
        run_req(OP_XOR, 1'b0, 32'h3C, 64'hFFFFFFFF_00000000, 8'h00, 3'd2, lat, rd, er);
        check_eq("xor_mem", mem[7], 64'h0F0F0F0F_AAAAAAAA);
        run_req(OP_SWAP, 1'b0, 32'h48, 64'hCAFEBABE_CAFEBABE, 8'h00, 3'd3, lat, rd, er);
        check_eq("swap_rsp", rd, 64'h1234);
        check_eq("swap_mem", mem[9], 64'hCAFEBABE_CAFEBABE);

        // Errors: illegal opcode, illegal AMO size
        rc = rd_cnt; wc = wr_cnt;
        run_req(4'hD, 1'b0, 32'h10, 64'h0, 8'h00, 3'd3, lat, rd, er);
        check_eq("ill_lat",  64'(lat), 64'd1);
        check_eq("ill_err",  64'(er), 64'd1);
        check_eq("ill_data", rd, 64'd0);
        run_req(OP_SWAP, 1'b0, 32'h10, 64'h5, 8'h00, 3'd1, lat, rd, er);
        check_eq("sz_lat",  64'(lat), 64'd1);
        check_eq("sz_err",  64'(er), 64'd1);
        check_eq("err_noacc", 64'((rd_cnt - rc) + (wr_cnt - wc)), 64'd0);

`ifdef REQRSP_AMO_LRSC_EN
        poke(8, 64'h55);
        run_req(OP_LR, 1'b0, 32'h40, 64'h0, 8'h00, 3'd3, lat, rd, er);
        check_eq("lr_data", rd, 64'h55);
        wc = wr_cnt;
        run_req(OP_SC, 1'b1, 32'h40, 64'h77, 8'hFF, 3'd3, lat, rd, er);
        check_eq("sc_ok_rsp", rd, 64'd0);
        check_eq("sc_ok_err", 64'(er), 64'd0);
        check_eq("sc_ok_wr",  64'(wr_cnt - wc), 64'd1);
        check_eq("sc_ok_mem", mem[8], 64'h77);
        run_req(OP_LR, 1'b0, 32'h40, 64'h0, 8'h00, 3'd3, lat, rd, er);
        run_req(OP_NONE, 1'b1, 32'h40, 64'h99, 8'hFF, 3'd3, lat, rd, er);
        wc = wr_cnt;
        run_req(OP_SC, 1'b1, 32'h40, 64'hAA, 8'hFF, 3'd3, lat, rd, er);
        check_eq("sc_fail_rsp", rd, 64'd1);
        check_eq("sc_fail_lat", 64'(lat), 64'd1);
        check_eq("sc_fail_wr",  64'(wr_cnt - wc), 64'd0);
        check_eq("sc_fail_mem", mem[8], 64'h99);
`else
        rc = rd_cnt; wc = wr_cnt;
        run_req(OP_SC, 1'b1, 32'h40, 64'h77, 8'hFF, 3'd3, lat, rd, er);
        check_eq("sc_err",   64'(er), 64'd1);
        check_eq("sc_lat",   64'(lat), 64'd1);
        check_eq("sc_noacc", 64'((rd_cnt - rc) + (wr_cnt - wc)), 64'd0);
        run_req(OP_LR, 1'b0, 32'h10, 64'h0, 8'h00, 3'd3, lat, rd, er);
        check_eq("lr_load", rd, 64'hDEADBEEF_01234567);
        check_eq("lr_lat",  64'(lat), 64'd3);
`endif

        // gnt stalled 3 cycles, rsp_ready low 2 cycles
        poke(11, 64'h0);
        gnt_en = 1'b0; rsp_ready = 1'b0;
        req_amo = OP_NONE; req_write = 1'b1; req_addr = 32'h58;
        req_data = 64'hA5A5A5A5_5A5A5A5A; req_strb = 8'hFF; req_size = 3'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 4) begin
                check_eq($sformatf("stall_req_c%0d", c), 64'(mem_req), 64'd1);
                check_eq($sformatf("stall_addr_c%0d", c), 64'(mem_addr), 64'h58);
                check_eq($sformatf("stall_wdata_c%0d", c), mem_wdata, 64'hA5A5A5A5_5A5A5A5A);
            end
            if (c == 4) gnt_en = 1'b1;
            if (c == 5) check_eq("stall_c5_valid", 64'(rsp_valid), 64'd0);
            if (c >= 6 && c <= 8) begin
                check_eq($sformatf("hold_valid_c%0d", c), 64'(rsp_valid), 64'd1);
                check_eq($sformatf("hold_data_c%0d", c), rsp_data, 64'd0);
            end
            if (c == 8) rsp_ready = 1'b1;
            if (c == 9) begin
                check_eq("hold_done_valid", 64'(rsp_valid), 64'd0);
                check_eq("hold_done_ready", 64'(req_ready), 64'd1);
            end
            @(posedge clk); #1;
        end
        check_eq("stall_mem", mem[11], 64'hA5A5A5A5_5A5A5A5A);

        // Reset pulsed while waiting for the write response
        req_amo = OP_NONE; req_write = 1'b1; req_addr = 32'h60;
        req_data = 64'h1; req_strb = 8'hFF; req_size = 3'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("rp_c1_we", 64'(mem_we), 64'd1);
        @(posedge clk); #1;
        check_eq("rp_c2_req", 64'(mem_req), 64'd0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        check_eq("rp_ready", 64'(req_ready), 64'd1);
        check_eq("rp_addr",  64'(mem_addr), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check_eq($sformatf("rp_novalid_%0d", c), 64'(rsp_valid), 64'd0);
            check_eq($sformatf("rp_idle_%0d", c), 64'(req_ready), 64'd1);
        end
        run_req(OP_NONE, 1'b0, 32'h10, 64'h0, 8'h00, 3'd3, lat, rd, er);
        check_eq("rp_after_load", rd, 64'hDEADBEEF_01234567);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/reqrsp_to_mem_amo.md
# reqrsp_to_mem_amo

Terminates a reqrsp request/response port onto a single-port, req/gnt SRAM-style memory, executing the reqrsp atomic operations as read-modify-write sequences. Sits directly downstream of any reqrsp master (core, demux, or AXI-to-reqrsp converter) that encodes atomics with `reqrsp_pkg::amo_op_e`. It is the memory-side consumer of that encoding. One transaction is in flight at a time.

## Interface
Parameters:
- `AddrWidth`, 32: request and memory address width.
- `DataWidth`, 64: data bus width. Legal values are 32 and 64.
- `StrbWidth`, DataWidth/8: byte-enable width (derived).

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1, `req_ready_o` out 1: request handshake.
- `req_addr_i` in AddrWidth: byte address.
- `req_write_i` in 1: store when high. Ignored for AMOs.
- `req_data_i` in DataWidth: store data or AMO operand, lane-aligned.
- `req_strb_i` in StrbWidth: store byte enables.
- `req_size_i` in `reqrsp_pkg::size_t`: log2 of access bytes.
- `req_amo_i` in `reqrsp_pkg::amo_op_e`: atomic opcode.
- `rsp_valid_o` out 1, `rsp_ready_i` in 1: response handshake.
- `rsp_data_o` out DataWidth: response data.
- `rsp_error_o` out 1: error flag.
- `mem_req_o` out 1, `mem_gnt_i` in 1: memory request handshake.
- `mem_addr_o` out AddrWidth: address, aligned to DataWidth/8.
- `mem_we_o` out 1: write enable.
- `mem_wdata_o` out DataWidth: write data.
- `mem_be_o` out StrbWidth: byte enables.
- `mem_rvalid_i` in 1: response valid. Arrives exactly one cycle after `mem_gnt_i`, for reads and writes.
- `mem_rdata_i` in DataWidth: read data.

## Operation
- FSM states: IDLE, MEM_RD, WAIT_RD, MEM_WR, WAIT_WR, RESP.
- `req_ready_o` = (state == IDLE). On accept, all request fields are registered.
- Request classification:
  - Plain load: `AMONone`, `!req_write_i`.
  - Plain store: `AMONone`, `req_write_i`.
  - AMO: `reqrsp_pkg::is_amo` is true.
  - LR and SC: see Configuration.
  - Opcodes 0xC–0xF: illegal.
- Load: IDLE→MEM_RD→WAIT_RD→RESP. `mem_be_o` is all ones. `rsp_data_o` = `mem_rdata_i`.
- Store: IDLE→MEM_WR→WAIT_WR→RESP. `mem_be_o` = `req_strb_i`. `rsp_data_o` = 0.
- AMO: IDLE→MEM_RD→WAIT_RD→MEM_WR→WAIT_WR→RESP.
  - Operand width W = 8<<size. Legal sizes are 2, and 3 only when DataWidth=64.
  - The operand lane is selected by `addr[2]` when W=32 and DataWidth=64.
  - Write data = f(old, operand) in that lane. `mem_be_o` covers only that lane's bytes.
  - Swap: result = operand.
  - Add: result = (old + operand) mod 2^W.
  - And, Or, Xor: bitwise.
  - Max and Min: signed compare on W bits. Maxu and Minu: unsigned compare.
  - `rsp_data_o` = old read data, full bus.
- Errors: illegal opcode, or an AMO with an illegal size, takes IDLE→RESP directly. No memory access occurs. The response has `rsp_error_o`=1 and `rsp_data_o`=0.
- MEM_RD and MEM_WR hold `mem_req_o`=1 with stable address, data and byte enables until `mem_gnt_i`.
- `mem_rvalid_i` is ignored outside WAIT_RD and WAIT_WR.
- RESP holds `rsp_valid_o`, `rsp_data_o` and `rsp_error_o` stable until `rsp_ready_i`, then returns to IDLE.

## Timing
- Reset values:
  - `req_ready_o`=1 (state IDLE).
  - `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `mem_be_o`=0.
  - `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_error_o`=0.
  - Reservation invalid.
- Latency is measured from the accept cycle c0, with `mem_gnt_i` immediate and `rsp_ready_i`=1:
  - Load or store: `mem_req_o` in c1, `rsp_valid_o` in c3.
  - AMO: read in c1, write in c3, `rsp_valid_o` in c5.
  - Error: `rsp_valid_o` in c1.
- Each gnt stall cycle adds one cycle.
- Back-to-back throughput: the next accept occurs in the cycle after the response handshake.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and no response is produced. A pending `mem_rvalid_i` after reset release is ignored.
- All outputs are driven from registers or the state decode. There is no combinational path from the `rsp_ready_i` or `mem_*` inputs to `req_ready_o`.

## Configuration
- `REQRSP_AMO_LRSC_EN` defined:
  - One reservation register holds a valid bit and a DataWidth-aligned address.
  - LR: behaves as a load and sets the reservation to the address.
  - SC, reservation valid and address match: store path with `req_strb_i`, `rsp_data_o`=0.
  - SC, otherwise: no memory access, IDLE→RESP, `rsp_data_o`=1.
  - Every SC clears the reservation.
  - A store or AMO to the reserved address clears it when the write is granted.
- `REQRSP_AMO_LRSC_EN` undefined:
  - LR is treated as a plain load.
  - SC returns an error with no memory access.
  - No reservation state exists.

## Test plan
- Reset, then load from 0x10 with memory word 0xDEADBEEF_01234567 → `rsp_valid_o` in c3 with that data, `rsp_error_o`=0.
- AMOAdd, size 2, addr 0x4, operand 0x00000001_00000000, old word 0xFFFFFFFF in the upper lane → write `mem_be_o`=0xF0, upper lane 0x00000000, response is the old word.
- AMOMax vs AMOMaxu, W=32, old 0x80000000, operand 0x00000001 → written value 0x00000001 for Max and 0x80000000 for Maxu.
- Opcode 0xD, and AMOSwap with size 1 → no `mem_req_o`, error response in c1.
- With `REQRSP_AMO_LRSC_EN`: LR 0x40, SC 0x40 → response 0 with a write. LR 0x40, store 0x40, SC 0x40 → response 1 and no SC write.
- `mem_gnt_i` held low for 3 cycles and `rsp_ready_i` low for 2 cycles → outputs stay stable. Reset pulsed in WAIT_WR → no response, `req_ready_o`=1.
